// File: rtl/time_counter.sv
// time_counter
//   24-hour HH:MM:SS timekeeper driven by a prescaled system clock.
//   Sits downstream of the switch controller and feeds the display decoder.
//
// Ports
//   clk, reset_n        system clock (rising edge) and async active-low reset
//   clock_enable        1 = time advances, 0 = frozen
//   set_mode            1 = load time from set_hour/set_minute/set_second
//   reset_clock         1 = clear time to 00:00:00
//   set_hour/minute/second  values to load (clamped to 23/59/59)
//   hour, minute, second    current binary time
//   *_bcd               {tens, ones} BCD of the binary time, no added latency
//   sec_pulse           one cycle, aligned with every second increment
//   day_pulse           one cycle, aligned with 23:59:59 -> 00:00:00
//   avs_*               read-only Avalon-MM slave, 1-cycle read latency
//     addr 0: {15'h0, hour, minute, second}
//     addr 1: {8'h0, hour_bcd, minute_bcd, second_bcd}
//     addr 2: {30'h0, mode}   RUN=0 PAUSE=1 SET=2 CLEAR=3
//     addr 3: {16'h0, day_count}
//
// Handshake: avs_waitrequest is constant 0, so every cycle with avs_read=1 is
// an accepted read; avs_readdata presents the result on the following cycle
// and holds it until the next accepted read.
module time_counter #(
  parameter int TICK_DIV   = 50000000,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clock_enable,
  input  logic                  set_mode,
  input  logic                  reset_clock,
  input  logic [4:0]            set_hour,
  input  logic [5:0]            set_minute,
  input  logic [5:0]            set_second,
  output logic [4:0]            hour,
  output logic [5:0]            minute,
  output logic [5:0]            second,
  output logic [7:0]            hour_bcd,
  output logic [7:0]            minute_bcd,
  output logic [7:0]            second_bcd,
  output logic                  sec_pulse,
  output logic                  day_pulse,
  input  logic [1:0]            avs_address,
  input  logic                  avs_read,
  output logic [DATA_WIDTH-1:0] avs_readdata,
  output logic                  avs_waitrequest
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_PAUSE = 2'd1,
    MODE_SET   = 2'd2,
    MODE_CLEAR = 2'd3
  } mode_t;

  logic [PW-1:0] prescaler;
  logic [15:0]   day_count;
  mode_t         mode;
  mode_t         mode_next;

  // Priority: reset_clock > set_mode > !clock_enable > run. The time logic
  // acts on this directly; the mode register only records it for software.
  always_comb begin
    mode_next = MODE_RUN;
    if (reset_clock)       mode_next = MODE_CLEAR;
    else if (set_mode)     mode_next = MODE_SET;
    else if (!clock_enable) mode_next = MODE_PAUSE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= '0;
      hour      <= '0;
      minute    <= '0;
      second    <= '0;
      day_count <= '0;
      mode      <= MODE_RUN;
      sec_pulse <= 1'b0;
      day_pulse <= 1'b0;
    end else begin
      mode      <= mode_next;
      sec_pulse <= 1'b0;
      day_pulse <= 1'b0;
      case (mode_next)
        MODE_CLEAR: begin
          prescaler <= '0;
          hour      <= '0;
          minute    <= '0;
          second    <= '0;
        end
        MODE_SET: begin
          // Prescaler held at 0 so the first tick after release is a full second.
          prescaler <= '0;
          hour      <= (set_hour   > 5'd23) ? 5'd23 : set_hour;
          minute    <= (set_minute > 6'd59) ? 6'd59 : set_minute;
          second    <= (set_second > 6'd59) ? 6'd59 : set_second;
        end
        MODE_PAUSE: begin
          // hold everything
        end
        default: begin
          if (prescaler == TICK_LAST) begin
            prescaler <= '0;
            sec_pulse <= 1'b1;
            if (second == 6'd59) begin
              second <= '0;
              if (minute == 6'd59) begin
                minute <= '0;
                if (hour == 5'd23) begin
                  hour      <= '0;
                  day_pulse <= 1'b1;
                  day_count <= day_count + 16'd1;
                end else begin
                  hour <= hour + 5'd1;
                end
              end else begin
                minute <= minute + 6'd1;
              end
            end else begin
              second <= second + 6'd1;
            end
          end else begin
            prescaler <= prescaler + 1'b1;
          end
        end
      endcase
    end
  end

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    return {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

  assign hour_bcd   = to_bcd({1'b0, hour});
  assign minute_bcd = to_bcd(minute);
  assign second_bcd = to_bcd(second);

  assign avs_waitrequest = 1'b0;

  // Registered read: sampling the current registers gives the pre-increment
  // value when a read coincides with a tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      case (avs_address)
        2'd0:    avs_readdata <= {15'h0, hour, minute, second};
        2'd1:    avs_readdata <= {8'h0, hour_bcd, minute_bcd, second_bcd};
        2'd2:    avs_readdata <= {30'h0, mode};
        default: avs_readdata <= {16'h0, day_count};
      endcase
    end
  end

endmodule

// File: tb/tb_time_counter.sv
// tb_time_counter
//   Self-checking bench for time_counter with TICK_DIV=4. A reference model
//   keeps time as seconds-of-day plus a tick phase and is stepped once per
//   rising edge; every output is compared on the following falling edge.
module tb_time_counter;

  localparam int TICK_DIV = 4;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clock_enable = 1'b0;
  logic        set_mode = 1'b0;
  logic        reset_clock = 1'b0;
  logic [4:0]  set_hour = '0;
  logic [5:0]  set_minute = '0;
  logic [5:0]  set_second = '0;
  logic [4:0]  hour;
  logic [5:0]  minute;
  logic [5:0]  second;
  logic [7:0]  hour_bcd;
  logic [7:0]  minute_bcd;
  logic [7:0]  second_bcd;
  logic        sec_pulse;
  logic        day_pulse;
  logic [1:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;

  always #5 clk = ~clk;

  time_counter #(.TICK_DIV(TICK_DIV), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .clock_enable(clock_enable),
    .set_mode(set_mode), .reset_clock(reset_clock),
    .set_hour(set_hour), .set_minute(set_minute), .set_second(set_second),
    .hour(hour), .minute(minute), .second(second),
    .hour_bcd(hour_bcd), .minute_bcd(minute_bcd), .second_bcd(second_bcd),
    .sec_pulse(sec_pulse), .day_pulse(day_pulse),
    .avs_address(avs_address), .avs_read(avs_read),
    .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model
  int          m_tod;    // seconds since midnight, 0..86399
  int          m_day;
  int          m_phase;  // cycles into the current second
  int          m_mode;
  bit          m_sp;
  bit          m_dp;
  logic [31:0] m_rd;

  function automatic int hh(); return m_tod / 3600;       endfunction
  function automatic int mm(); return (m_tod / 60) % 60;  endfunction
  function automatic int ss(); return m_tod % 60;         endfunction

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic logic [31:0] reg_val(input int a);
    case (a)
      0:       return 32'(hh() * 4096 + mm() * 64 + ss());
      1:       return {8'h0, bcd(hh()), bcd(mm()), bcd(ss())};
      2:       return 32'(m_mode);
      default: return 32'(m_day);
    endcase
  endfunction

  task automatic model_reset();
    m_tod = 0; m_day = 0; m_phase = 0; m_mode = 0;
    m_sp = 0; m_dp = 0; m_rd = '0;
  endtask

  task automatic model_edge();
    int h, mi, s;
    if (avs_read) m_rd = reg_val(int'(avs_address));
    m_sp = 0;
    m_dp = 0;
    if (reset_clock) begin
      m_mode = 3; m_tod = 0; m_phase = 0;
    end else if (set_mode) begin
      m_mode = 2;
      h  = (int'(set_hour)   > 23) ? 23 : int'(set_hour);
      mi = (int'(set_minute) > 59) ? 59 : int'(set_minute);
      s  = (int'(set_second) > 59) ? 59 : int'(set_second);
      m_tod = h * 3600 + mi * 60 + s;
      m_phase = 0;
    end else if (!clock_enable) begin
      m_mode = 1;
    end else begin
      m_mode = 0;
      m_phase++;
      if (m_phase == TICK_DIV) begin
        m_phase = 0;
        m_sp = 1;
        m_tod++;
        if (m_tod == 86400) begin
          m_tod = 0;
          m_dp = 1;
          m_day = (m_day + 1) % 65536;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("hour",       32'(hour),       32'(hh()));
    check("minute",     32'(minute),     32'(mm()));
    check("second",     32'(second),     32'(ss()));
    check("hour_bcd",   32'(hour_bcd),   32'(bcd(hh())));
    check("minute_bcd", 32'(minute_bcd), 32'(bcd(mm())));
    check("second_bcd", 32'(second_bcd), 32'(bcd(ss())));
    check("sec_pulse",  32'(sec_pulse),  32'(m_sp));
    check("day_pulse",  32'(day_pulse),  32'(m_dp));
    check("readdata",   avs_readdata,    m_rd);
    check("waitreq",    32'(avs_waitrequest), 32'd0);
  endtask

  // drivers (inputs change only on falling edges)
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic drive_set(input int h, input int mi, input int s);
    set_mode   = 1'b1;
    set_hour   = 5'(h);
    set_minute = 6'(mi);
    set_second = 6'(s);
  endtask

  task automatic read_reg(input int a);
    avs_read = 1'b1;
    avs_address = 2'(a);
    step();
    avs_read = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    reset_n = 1'b1;

    // free-run: first increment on the 4th edge, pulse lasts one cycle
    clock_enable = 1'b1;
    run(3);
    check("t1_sec_before", 32'(second), 32'd0);
    step();
    check("t1_sec_4th", 32'(second), 32'd1);
    check("t1_pulse_4th", 32'(sec_pulse), 32'd1);
    step();
    check("t1_pulse_gone", 32'(sec_pulse), 32'd0);
    run(3);
    check("t1_sec_8th", 32'(second), 32'd2);

    // day rollover from 23:59:58
    drive_set(23, 59, 58);
    run(3);
    set_mode = 1'b0;
    run(7);
    check("t2_day_pulse_pre", 32'(day_pulse), 32'd0);
    step();
    check("t2_time", {hour_bcd, minute_bcd, second_bcd}, 32'd0);
    check("t2_day_pulse", 32'(day_pulse), 32'd1);
    read_reg(3);
    check("t2_day_count", avs_readdata, 32'h1);

    // clamping of out-of-range set values; mode reads SET
    drive_set(30, 63, 61);
    step();
    check("t3_clamp", {11'h0, hour, minute, second}, {11'h0, 5'd23, 6'd59, 6'd59});
    read_reg(2);
    check("t3_mode", avs_readdata, 32'd2);

    // pause with prescaler at 2, then resume
    set_mode = 1'b0;
    run(2);
    clock_enable = 1'b0;
    run(10);
    check("t4_frozen", 32'(second), 32'd59);
    clock_enable = 1'b1;
    step();
    check("t4_resume1", 32'(second), 32'd59);
    step();
    check("t4_resume2", 32'(second), 32'd0);
    check("t4_day", 32'(day_pulse), 32'd1);

    // clear beats set
    drive_set(12, 34, 56);
    step();
    reset_clock = 1'b1;
    step();
    check("t5_clear", 32'(second) + 32'(minute) + 32'(hour), 32'd0);
    read_reg(2);
    check("t5_mode", avs_readdata, 32'd3);
    reset_clock = 1'b0;

    // register reads of 12:34:56
    step();
    set_mode = 1'b0;
    clock_enable = 1'b0;
    read_reg(1);
    check("t6_bcd_read", avs_readdata, 32'h00123456);
    read_reg(0);
    check("t6_bin_read", avs_readdata, 32'h0000C8B8);

    // reset mid-count discards the prescaler phase
    clock_enable = 1'b1;
    run(6);
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset_n = 1'b1;
    run(3);
    check("t7_no_early", 32'(second), 32'd0);
    step();
    check("t7_restart", 32'(second), 32'd1);

    // randomized operation mix
    for (int i = 0; i < 400; i++) begin
      int op;
      op = $urandom_range(0, 9);
      reset_clock = 1'b0;
      set_mode = 1'b0;
      clock_enable = 1'b1;
      if (op == 0) begin
        reset_clock = 1'b1;
        set_mode = 1'($urandom_range(0, 1));
      end else if (op <= 2) begin
        if ($urandom_range(0, 1) == 1)
          drive_set(23, $urandom_range(58, 63), $urandom_range(55, 63));
        else
          drive_set($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
        clock_enable = 1'($urandom_range(0, 1));
      end else if (op == 3) begin
        clock_enable = 1'b0;
      end
      repeat ($urandom_range(1, 12)) begin
        avs_read = 1'($urandom_range(0, 1));
        avs_address = 2'($urandom_range(0, 3));
        step();
      end
    end
    avs_read = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
